imm_decode_stage: RTL
=====================

Name: imm_decode_stage

Overview:
- Registered, flow-controlled immediate-decode pipeline stage between fetch and execute.
- Each accepted instruction produces:
  - its format class;
  - the sign- or zero-extended immediate at XLEN width;
  - an illegal-opcode flag;
  - optionally the PC-relative target (pc+imm).
- Covers all base RV formats (I, S, B, U, J, R/none). Adds valid/ready backpressure, flush, and an XLEN of 32 or 64.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- SHAMT_ZEXT, 1, 1: shift-immediates (OP-IMM, funct3 001/101) output the zero-extended shamt field; 0: plain I-type sign extension.
- TARGET_EN, 1, 1: compute out_target = out_pc + out_imm; 0: out_target tied to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  instruction passed through.
- out_pc  out  XLEN  pc passed through.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  imm_fmt_e format class.
- out_illegal  out  1  opcode not recognised.
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, in_ready=1.
  - out_imm, out_pc, out_instr, out_target = 0; out_fmt=FMT_NONE; out_illegal=0.
  - Both buffer entries empty.
- Transfers:
  - In transfer: in_valid & in_ready. Out transfer: out_valid & out_ready.
  - Upstream must hold in_valid and payload stable until accepted. out_valid never drops without an out transfer or flush.
- Storage: 2-entry skid, main register plus skid register.
  - in_ready is registered: in_ready = !skid_full. There is no combinational path from out_ready to in_ready.
- Latency: 1 cycle from in transfer to out_valid when the main register is empty or draining. Full throughput is 1/cycle with out_ready held high.
- Buffer updates:
  - Main empty or draining this cycle: the new input (or the skid entry, if occupied) loads main.
  - Main held (out_valid & !out_ready) and in transfer: input goes to skid. Skid becomes full and in_ready=0 next cycle.
  - Skid drains into main on the next out transfer; in_ready returns to 1 the following cycle.
  - Ordering is strictly FIFO; no loss, no duplication.
- Flush:
  - Empties both entries; out_valid=0 and in_ready=1 next cycle.
  - An in transfer in the flush cycle is discarded.
  - Flush has priority over every other event in the same cycle.
- Decode is done before the main register, so outputs are fully registered.
- Format by opcode:
  - ITYPE, LOAD, JALR -> FMT_I: sign-extend instr[31:20].
  - STORE -> FMT_S: sign-extend {instr[31:25], instr[11:7]}.
  - BTYPE -> FMT_B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - LUI, AUIPC -> FMT_U: sign-extend {instr[31:12], 12'b0}. For XLEN=64, bits 63:32 copy bit 31.
  - JAL -> FMT_J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - RTYPE -> FMT_NONE, imm=0.
  - Any other opcode -> FMT_NONE, imm=0, illegal=1.
- Shift-immediate override (SHAMT_ZEXT=1, ITYPE with funct3 001/101):
  - imm = zero-extended instr[24:20] for XLEN=32.
  - imm = zero-extended instr[25:20] for XLEN=64.
- out_target is computed for every format and the adder wraps. Consumers use it only for B, J, AUIPC.
- Reset asserted mid-stream: all entries are lost, and outputs go to reset values immediately (async).

Decomposition:
- Shared package cpu_defs holds:
  - imm_fmt_e enum: FMT_NONE=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J.
  - New opcode constants OPCODE_LUI, OPCODE_AUIPC, OPCODE_RTYPE, alongside the existing opcode set.
  - FUNCT3_SLLI=3'b001, FUNCT3_SRXI=3'b101.
- One combinational sub-module, imm_extract, parametrised by XLEN and SHAMT_ZEXT:
  - Input: instr. Outputs: imm, fmt, illegal.
- imm_decode_stage owns the skid buffer, flush, and target adder.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=FMT_I, illegal=0.
- LUI (0x123450B7) -> imm=0x12345000, FMT_U. With XLEN=64, LUI 0x800000B7 -> imm=0xFFFFFFFF80000000.
- PC-relative targets:
  - JAL x0,+8 (0x0080006F) at pc=0x100 -> imm=8, FMT_J, target=0x108.
  - BEQ x0,x0,-4 (0xFE000EE3) at pc=0x200 -> imm=0xFFFFFFFC, FMT_B, target=0x1FC.
- SRAI x1,x1,3 (0x4030D093) -> SHAMT_ZEXT=1: imm=3; SHAMT_ZEXT=0: imm=0x403. Opcode 0x7F -> illegal=1, imm=0.
- Backpressure: out_ready=0 for 4 cycles while 3 instructions are offered back-to-back -> 2 accepted, in_ready=0 from the cycle after the 2nd. Then out_ready=1 -> all 3 emerge in order, no gaps, no duplicates.
- Flush with both entries full, plus in_valid the same cycle -> next cycle out_valid=0, in_ready=1, the flushed-cycle input never appears. Async rst mid-stream -> outputs zero immediately.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: immediate format classes, opcode map and the
// funct3 codes that select the shift-immediate instructions.
package cpu_defs;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_BTYPE = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;

  localparam logic [2:0] FUNCT3_SLLI = 3'b001;
  localparam logic [2:0] FUNCT3_SRXI = 3'b101;

  // True for the OP-IMM encodings whose immediate field carries a shamt.
  function automatic logic is_shift_funct3(input logic [2:0] funct3);
    return (funct3 == FUNCT3_SLLI) || (funct3 == FUNCT3_SRXI);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor: classifies the instruction format,
// assembles the immediate and extends it to XLEN (XLEN must be 32 or 64).
module imm_extract
  import cpu_defs::*;
#(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  // RV64 shifts carry a 6-bit shamt, RV32 a 5-bit one.
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic        zext;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Build a 32-bit immediate per format; zext marks the unsigned shamt case.
  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    zext    = 1'b0;
    case (opcode)
      OPCODE_LOAD, OPCODE_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPCODE_ITYPE: begin
        fmt = FMT_I;
        if (SHAMT_ZEXT && is_shift_funct3(funct3)) begin
          zext  = 1'b1;
          imm32 = 32'(instr[20 +: SHAMT_W]);
        end else begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPCODE_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPCODE_BTYPE: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPCODE_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPCODE_RTYPE: begin
        fmt = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Widen to XLEN: shamt is zero-extended, every other format sign-extends bit 31.
  assign imm = zext ? XLEN'(imm32) : XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: decodes on the input side, then holds the
// result in a two-entry skid buffer (main + skid) with registered in_ready.
module imm_decode_stage
  import cpu_defs::*;
#(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1'b1,
  parameter bit TARGET_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_target;

  logic            main_valid_reg;
  logic [31:0]     main_instr_reg;
  logic [XLEN-1:0] main_pc_reg;
  logic [XLEN-1:0] main_imm_reg;
  imm_fmt_e        main_fmt_reg;
  logic            main_illegal_reg;
  logic [XLEN-1:0] main_target_reg;

  logic            skid_full_reg;
  logic [31:0]     skid_instr_reg;
  logic [XLEN-1:0] skid_pc_reg;
  logic [XLEN-1:0] skid_imm_reg;
  imm_fmt_e        skid_fmt_reg;
  logic            skid_illegal_reg;
  logic [XLEN-1:0] skid_target_reg;

  logic in_xfer;
  logic main_free;

  imm_extract #(
    .XLEN       (XLEN),
    .SHAMT_ZEXT (SHAMT_ZEXT)
  ) u_imm_extract (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Target is computed ahead of the register so out_target stays registered.
  generate
    if (TARGET_EN) begin : g_target
      assign dec_target = in_pc + dec_imm;
    end else begin : g_no_target
      assign dec_target = '0;
    end
  endgenerate

  // in_ready depends only on state, never on out_ready in the same cycle.
  assign in_ready  = !skid_full_reg;
  assign in_xfer   = in_valid && in_ready;
  assign main_free = !main_valid_reg || out_ready;

  assign out_valid   = main_valid_reg;
  assign out_instr   = main_instr_reg;
  assign out_pc      = main_pc_reg;
  assign out_imm     = main_imm_reg;
  assign out_fmt     = main_fmt_reg;
  assign out_illegal = main_illegal_reg;
  assign out_target  = main_target_reg;

  // Skid buffer: main refills from skid first (FIFO order), else from input;
  // a held main diverts the incoming item into skid. Flush wins over all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg   <= 1'b0;
      main_instr_reg   <= '0;
      main_pc_reg      <= '0;
      main_imm_reg     <= '0;
      main_fmt_reg     <= FMT_NONE;
      main_illegal_reg <= 1'b0;
      main_target_reg  <= '0;
      skid_full_reg    <= 1'b0;
      skid_instr_reg   <= '0;
      skid_pc_reg      <= '0;
      skid_imm_reg     <= '0;
      skid_fmt_reg     <= FMT_NONE;
      skid_illegal_reg <= 1'b0;
      skid_target_reg  <= '0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_full_reg  <= 1'b0;
    end else if (main_free) begin
      if (skid_full_reg) begin
        main_valid_reg   <= 1'b1;
        main_instr_reg   <= skid_instr_reg;
        main_pc_reg      <= skid_pc_reg;
        main_imm_reg     <= skid_imm_reg;
        main_fmt_reg     <= skid_fmt_reg;
        main_illegal_reg <= skid_illegal_reg;
        main_target_reg  <= skid_target_reg;
        skid_full_reg    <= 1'b0;
      end else if (in_xfer) begin
        main_valid_reg   <= 1'b1;
        main_instr_reg   <= in_instr;
        main_pc_reg      <= in_pc;
        main_imm_reg     <= dec_imm;
        main_fmt_reg     <= dec_fmt;
        main_illegal_reg <= dec_illegal;
        main_target_reg  <= dec_target;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_full_reg    <= 1'b1;
      skid_instr_reg   <= in_instr;
      skid_pc_reg      <= in_pc;
      skid_imm_reg     <= dec_imm;
      skid_fmt_reg     <= dec_fmt;
      skid_illegal_reg <= dec_illegal;
      skid_target_reg  <= dec_target;
    end
  end

endmodule
